// File: rtl/sprite_table_writer.sv
// -----------------------------------------------------------------------------
// sprite_table_writer
//
// Packs sprite attributes into the 18-bit sprite-table word
// {anchor_x, anchor_y, sprite_layer, sprite_id} and writes it into the sprite
// attribute RAM. It also sweeps the whole table to zero, either on command or
// automatically after reset release (CLEAR_ON_RESET = 1).
//
// Parameters:
//   SLOTS           number of table entries (1..32)
//   CLEAR_ON_RESET  1 = clear sweep right after reset release, 0 = start idle
//
// Ports:
//   clock         in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   cmd_valid     in   command present
//   cmd_ready     out  command can be accepted this cycle
//   cmd_op        in   0 = write one slot, 1 = clear whole table
//   cmd_slot      in   target slot of a write
//   anchor_x      in   word bits [17:14]
//   anchor_y      in   word bits [13:10]
//   sprite_layer  in   word bits [9:5]
//   sprite_id     in   word bits [4:0]
//   mem_we        out  memory write strobe
//   mem_addr      out  memory address (holds while mem_we = 0)
//   mem_data      out  memory write data (holds while mem_we = 0)
//   done          out  one-cycle pulse when a write or a commanded clear ends
//   err           out  one-cycle pulse when a write to an illegal slot is refused
// -----------------------------------------------------------------------------
module sprite_table_writer #(
    parameter int SLOTS          = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [4:0]  cmd_slot,
    input  logic [3:0]  anchor_x,
    input  logic [3:0]  anchor_y,
    input  logic [4:0]  sprite_layer,
    input  logic [4:0]  sprite_id,
    output logic        mem_we,
    output logic [4:0]  mem_addr,
    output logic [17:0] mem_data,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2,
        ST_INIT  = 2'd3
    } state_t;

    localparam state_t     RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
    localparam logic [5:0] SLOTS_W     = 6'(SLOTS);
    localparam logic [5:0] LAST_W      = 6'(SLOTS - 1);

    // Packed table word layout read back by the unpacking stage.
    function automatic logic [17:0] pack_word(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic [4:0] layer,
        input logic [4:0] id
    );
        return {x, y, layer, id};
    endfunction

    state_t      r_state;
    logic [5:0]  r_cnt;        // next sweep address; equals SLOTS once the sweep is exhausted
    logic        r_cmd_ready;
    logic        r_mem_we;
    logic [4:0]  r_mem_addr;
    logic [17:0] r_mem_data;
    logic        r_done;
    logic        r_err;

    state_t      w_state;
    logic [5:0]  w_cnt;
    logic        w_cmd_ready;
    logic        w_mem_we;
    logic [4:0]  w_mem_addr;
    logic [17:0] w_mem_data;
    logic        w_done;
    logic        w_err;

    // Next-state and next-output logic; outputs describe the cycle after the coming edge.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_cmd_ready = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_data  = r_mem_data;
        w_done      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                // r_cmd_ready is low only in the very first cycle after reset.
                if (cmd_valid && r_cmd_ready) begin
                    if (cmd_op == 1'b0) begin
                        if ({1'b0, cmd_slot} < SLOTS_W) begin
                            w_state     = ST_WRITE;
                            w_cmd_ready = 1'b0;
                            w_mem_we    = 1'b1;
                            w_mem_addr  = cmd_slot;
                            w_mem_data  = pack_word(anchor_x, anchor_y, sprite_layer, sprite_id);
                            w_done      = 1'b1;
                        end else begin
                            w_err = 1'b1;
                        end
                    end else begin
                        // The first sweep word already goes out on the accepting edge.
                        w_state     = ST_CLEAR;
                        w_cmd_ready = 1'b0;
                        w_mem_we    = 1'b1;
                        w_mem_addr  = 5'd0;
                        w_mem_data  = 18'd0;
                        w_done      = (LAST_W == 6'd0);
                        w_cnt       = 6'd1;
                    end
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_state     = ST_IDLE;
                w_cmd_ready = 1'b1;
            end
            ST_CLEAR, ST_INIT: begin
                if (r_cnt == SLOTS_W) begin
                    w_state     = ST_IDLE;
                    w_cmd_ready = 1'b1;
                    w_cnt       = 6'd0;
                end else begin
                    w_mem_we   = 1'b1;
                    w_mem_addr = r_cnt[4:0];
                    w_mem_data = 18'd0;
                    // Only a commanded clear reports completion; the reset sweep is silent.
                    w_done     = (r_state == ST_CLEAR) && (r_cnt == LAST_W);
                    w_cnt      = r_cnt + 6'd1;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_cnt   = 6'd0;
            end
        endcase
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state     <= RESET_STATE;
            r_cnt       <= 6'd0;
            r_cmd_ready <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 5'd0;
            r_mem_data  <= 18'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_cmd_ready <= w_cmd_ready;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_data  <= w_mem_data;
            r_done      <= w_done;
            r_err       <= w_err;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: doc/sprite_table_writer.md
# sprite_table_writer

Packs sprite attributes into the 18-bit sprite-table word format and writes them into the sprite attribute memory. It also provides a full-table clear sweep on command or after reset. It sits between the game-logic command side and the sprite attribute RAM. It produces exactly the words the sprite-table unpacking stage later reads back into anchor_x, anchor_y, sprite_layer and sprite_id.

## Interface
- SLOTS, 32: number of sprite-table entries; legal range 1..32.
- CLEAR_ON_RESET, 1: 1 = run a clear sweep automatically after reset release; 0 = go straight to idle.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_op  in  1  0 = write one slot; 1 = clear whole table.
- cmd_slot  in  5  target slot for a write; ignored for a clear.
- anchor_x  in  4  packed into bits [17:14].
- anchor_y  in  4  packed into bits [13:10].
- sprite_layer  in  5  packed into bits [9:5].
- sprite_id  in  5  packed into bits [4:0].
- mem_we  out  1  memory write strobe, one word per cycle.
- mem_addr  out  5  memory address.
- mem_data  out  18  memory write data.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse when a write is rejected.

## Operation
- All outputs are registered.
- A command is accepted on a rising edge where cmd_valid and cmd_ready are both 1. All command fields are sampled on that edge.
- Packing: word = {anchor_x, anchor_y, sprite_layer, sprite_id}. No other transformation.
- States:
  - IDLE: cmd_ready = 1.
    - Write accepted with cmd_slot < SLOTS: go to WRITE.
    - Write accepted with cmd_slot >= SLOTS: stay in IDLE, pulse err, no memory access, no done.
    - Clear accepted: go to CLEAR with the sweep counter at 0.
  - WRITE: mem_we = 1, mem_addr = latched slot, mem_data = packed word, done = 1. Go to IDLE.
  - CLEAR: mem_we = 1, mem_addr = counter, mem_data = 0.
    - Counter increments each cycle.
    - On the cycle with counter = SLOTS-1, also assert done and go to IDLE.
    - The counter never wraps: the sweep is exactly SLOTS writes.
  - INIT: entered on reset release when CLEAR_ON_RESET = 1. Behaves like CLEAR but done stays 0. Go to IDLE after SLOTS writes.
- cmd_ready = 0 in WRITE, CLEAR and INIT. cmd_valid is ignored in those states; the upstream holds the command until it is accepted.
- When mem_we = 0, mem_addr and mem_data hold their last value.

## Timing
- Reset values: cmd_ready = 0, mem_we = 0, mem_addr = 0, mem_data = 0, done = 0, err = 0. State is INIT if CLEAR_ON_RESET = 1, otherwise IDLE.
- First edge after reset release:
  - CLEAR_ON_RESET = 0: cmd_ready rises to 1.
  - CLEAR_ON_RESET = 1: the INIT sweep starts. mem_we is high for SLOTS cycles. cmd_ready rises on the edge that ends the last sweep write.
- Write latency: accept on edge k. The mem_we/done cycle runs from edge k to edge k+1. cmd_ready returns to 1 at edge k+1. Sustained throughput is one write per 2 cycles.
- Rejected write: err is high for the cycle after edge k. cmd_ready stays 1, so a new command can be accepted at edge k+1.
- Clear latency: accept on edge k. mem_we is high for SLOTS cycles starting after edge k. done coincides with the write to address SLOTS-1. cmd_ready returns to 1 at edge k+SLOTS.
- done and err are never asserted in the same cycle.
- rst asserted mid-WRITE or mid-CLEAR: outputs go to reset values immediately. The command is aborted with no done. If CLEAR_ON_RESET = 1, a fresh sweep starts from address 0 after release.

## Test plan
- Reset with CLEAR_ON_RESET = 1, SLOTS = 32, then release -> 32 consecutive mem_we cycles on addresses 0..31 with data 0, done never high, cmd_ready rises after address 31.
- Write slot 5 with anchor_x = 4'hA, anchor_y = 4'h3, sprite_layer = 5'd17, sprite_id = 5'd9 -> one mem_we cycle, mem_addr = 5, mem_data = 18'h28E29, done high that same cycle, cmd_ready back to 1 one cycle later.
- cmd_valid held high with two back-to-back writes to slots 0 and 31 -> accepts exactly 2 cycles apart, each with one write and one done, no lost or duplicated command.
- SLOTS = 20: write to slot 25 -> err for 1 cycle, no mem_we, no done, cmd_ready stays 1. Then write to slot 19 -> normal write at address 19.
- Clear command while CLEAR_ON_RESET = 0 -> SLOTS writes of 0, done coincides with the last address, cmd_valid ignored throughout the sweep.
- Assert rst on the 10th cycle of a clear sweep -> mem_we drops immediately, no done. After release with CLEAR_ON_RESET = 1, the sweep restarts at address 0.
